// File: rtl/bcd_seg_scan.sv
// Multiplexed common-anode 7-segment scanner for a packed BCD word.
// Words are double-buffered and swapped in only at frame boundaries.
module bcd_seg_scan #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGITS*4-1:0] bcd_in,
    input  logic                bcd_valid,
    output logic                bcd_ready,
    output logic [6:0]          seg_n,
    output logic [DIGITS-1:0]   an_n,
    output logic                frame_done
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PMax = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IMax = IW'(DIGITS - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       p_q, p_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS*4-1:0] disp_q, disp_d;
    logic [DIGITS*4-1:0] pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic                frame_d;
    logic                accept;
    logic [DIGITS-1:0]   blank;
    logic                above_zero;
    logic [3:0]          digit;
    logic [6:0]          seg_d;
    logic [DIGITS-1:0]   an_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    assign accept = bcd_valid && bcd_ready;

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        idx_d       = idx_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        frame_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StScan;
                    disp_d  = bcd_in;
                    p_d     = '0;
                    idx_d   = IMax;
                end
            end
            StScan: begin
                if (p_q == PMax) begin
                    p_d = '0;
                    if (idx_q == '0) begin
                        idx_d   = IMax;
                        frame_d = 1'b1;
                        // Boundary takes the old pending word; a same-edge accept refills it.
                        if (pend_full_q) begin
                            disp_d      = pend_q;
                            pend_full_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end else begin
                    p_d = p_q + PW'(1);
                end
                if (accept) begin
                    pend_d      = bcd_in;
                    pend_full_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are built from next-state values so the registered display lines up with p_q/idx_q.
    always_comb begin
        blank      = '0;
        above_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            above_zero = above_zero && (disp_d[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_LZ != 0) && above_zero;
        end
        digit = disp_d[{idx_d, 2'b00} +: 4];
        an_d  = '1;
        seg_d = 7'h7F;
        if ((state_d == StScan) && (p_d != '0) && !blank[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = seg_decode(digit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            p_q         <= '0;
            idx_q       <= IMax;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            bcd_ready   <= 1'b1;
            seg_n       <= 7'h7F;
            an_n        <= '1;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            bcd_ready   <= ~pend_full_d;
            seg_n       <= seg_d;
            an_n        <= an_d;
            frame_done  <= frame_d;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan (DIGITS=4, SCAN_DIV=4): per-cycle expected outputs
// are queued alongside stimulus and popped against the DUT one cycle at a time.
module tb_bcd_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = '0;
    logic        bcd_valid = 1'b0;
    logic        bcd_ready;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    logic [12:0] exp_q[$];
    logic [12:0] exp_v;
    logic [12:0] obs_v;

    localparam logic [12:0] Dark = {4'hF, 7'h7F, 1'b0, 1'b1};

    bcd_seg_scan #(
        .DIGITS  (4),
        .SCAN_DIV(4),
        .BLANK_LZ(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Cycle k after the accept edge: slot 3-(k%16)/4, prescaler k%4.
    function automatic logic [12:0] exp_out(input logic [15:0] w, input int k,
                                            input logic fd, input logic rdy);
        int         slot;
        int         p;
        logic [3:0] an;
        logic [6:0] seg;
        slot = 3 - (k % 16) / 4;
        p    = k % 4;
        an   = 4'hF;
        seg  = 7'h7F;
        if (p != 0 && !(slot != 0 && (w >> (4 * slot)) == 16'd0)) begin
            an[slot] = 1'b0;
            seg      = ref_seg(w[4*slot +: 4]);
        end
        return {an, seg, fd, rdy};
    endfunction

    task automatic push_run(input logic [15:0] w, input int k0, input int n, input bit first);
        for (int k = k0; k < k0 + n; k++) begin
            exp_q.push_back(exp_out(w, k, (k % 16 == 0) && !(first && k == 0), 1'b1));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bcd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Accept happens on the next edge; returns at the sample point of cycle k=0.
    task automatic send(input logic [15:0] w);
        bcd_in    = w;
        bcd_valid = 1'b1;
        @(posedge clk);
        #1;
        bcd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        send(16'h1234);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        obs_v = {an_n, seg_n, frame_done, bcd_ready};
        checks++;
        if (obs_v !== Dark)
            $display("FAIL async_reset got=%h exp=%h", obs_v, Dark);
        if (obs_v !== Dark) errors++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(Dark);
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp_v = exp_q.pop_front();
            obs_v = {an_n, seg_n, frame_done, bcd_ready};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_dark cyc=%0d got=%h exp=%h", n, obs_v, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_scan();
        do_reset();
        send(16'h1234);
        push_run(16'h1234, 0, 33, 1'b1);
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp_v = exp_q.pop_front();
            obs_v = {an_n, seg_n, frame_done, bcd_ready};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL scan_1234 cyc=%0d got=%h exp=%h", n, obs_v, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_blanking(input logic [15:0] w);
        do_reset();
        send(w);
        push_run(w, 0, 17, 1'b1);
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp_v = exp_q.pop_front();
            obs_v = {an_n, seg_n, frame_done, bcd_ready};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL blank_%h cyc=%0d got=%h exp=%h", w, n, obs_v, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(16'h1234);
        push_run(16'h1234, 0, 16, 1'b1);
        push_run(16'h9876, 16, 16, 1'b0);
        push_run(16'h5555, 32, 17, 1'b0);
        for (int i = 6; i < 16; i++) exp_q[i][0] = 1'b0;
        for (int i = 17; i < 32; i++) exp_q[i][0] = 1'b0;
        for (int i = 33; i < 48; i++) exp_q[i][0] = 1'b1;
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp_v = exp_q.pop_front();
            obs_v = {an_n, seg_n, frame_done, bcd_ready};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", n, obs_v, exp_v);
            end
            if (n == 5) begin
                bcd_in    = 16'h9876;
                bcd_valid = 1'b1;
            end
            if (n == 6) bcd_in = 16'h5555;
            if (n == 17) bcd_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        send(16'h1234);
        push_run(16'h1234, 0, 10, 1'b1);
        for (int i = 6; i < 10; i++) exp_q[i][0] = 1'b0;
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp_v = exp_q.pop_front();
            obs_v = {an_n, seg_n, frame_done, bcd_ready};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL pend_pre cyc=%0d got=%h exp=%h", n, obs_v, exp_v);
            end
            if (n == 5) begin
                bcd_in    = 16'h9876;
                bcd_valid = 1'b1;
            end
            if (n == 6) bcd_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        obs_v = {an_n, seg_n, frame_done, bcd_ready};
        checks++;
        if (obs_v !== Dark) begin
            errors++;
            $display("FAIL pend_async_reset got=%h exp=%h", obs_v, Dark);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(Dark);
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp_v = exp_q.pop_front();
            obs_v = {an_n, seg_n, frame_done, bcd_ready};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL pend_dark cyc=%0d got=%h exp=%h", n, obs_v, exp_v);
            end
            @(posedge clk);
            #1;
        end
        // A surviving pending word would replace 0007 at the first boundary.
        send(16'h0007);
        push_run(16'h0007, 0, 24, 1'b1);
        for (int n = 0; exp_q.size() > 0; n++) begin
            exp_v = exp_q.pop_front();
            obs_v = {an_n, seg_n, frame_done, bcd_ready};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL pend_reload cyc=%0d got=%h exp=%h", n, obs_v, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_scan();
        test_blanking(16'h0045);
        test_blanking(16'h0000);
        test_blanking(16'hA0F3);
        test_back_to_back();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
